// File: rtl/slave_mem_arb_pkg.sv
// Shared types for the two-requester slave memory arbiter.
// SLAVE_MEM_ARB_FIXED_PRIO_EN selects fixed priority in the picker; default is round-robin.
package slave_mem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/slave_mem_arb_picker.sv
// Winner select for the arbiter: round-robin pointer by default,
// fixed priority (requester 0 first) when SLAVE_MEM_ARB_FIXED_PRIO_EN is defined.
module slave_mem_arb_picker
  import slave_mem_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               grant_i,
  output req_id_t            winner_o
);

`ifdef SLAVE_MEM_ARB_FIXED_PRIO_EN
  logic unused_w;
  assign unused_w = clk_i ^ rst_ni ^ grant_i;

  always_comb begin
    winner_o = req_i[0] ? req_id_t'(0) : req_id_t'(1);
  end
`else
  req_id_t ptr_q;
  req_id_t ptr_d;

  // On a tie the pointer decides; after any grant it favours the other requester.
  always_comb begin
    if (&req_i) begin
      winner_o = ptr_q;
    end else begin
      winner_o = req_i[1] ? req_id_t'(1) : req_id_t'(0);
    end
    ptr_d = grant_i ? ~winner_o : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/slave_mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port slave memory (sync write, comb read).
// Define SLAVE_MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module slave_mem_arbiter
  import slave_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  req_id_t               id_q;
  req_id_t               winner;
  logic                  grant;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  slave_mem_arb_picker u_picker (
    .clk_i    (clk),
    .rst_ni   (rstn),
    .req_i    ({req1, req0}),
    .grant_i  (grant),
    .winner_o (winner)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes and address are only non-zero during the single ACCESS cycle.
  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    if (state_q == ACCESS) begin
      mem_wen   = we_q;
      mem_ren   = !we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    if (state_q == DONE) begin
      ack0 = (id_q == req_id_t'(0));
      ack1 = (id_q == req_id_t'(1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      id_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q <= winner;
        we_q <= (winner == req_id_t'(1)) ? we1 : we0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= (winner == req_id_t'(1)) ? addr1 : addr0;
      wdata_q <= (winner == req_id_t'(1)) ? wdata1 : wdata0;
    end
  end

  // Read data is captured at the edge that closes ACCESS and held until the next read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == ACCESS && !we_q) begin
      if (id_q == req_id_t'(0)) rdata0_q <= mem_rdata;
      else                      rdata1_q <= mem_rdata;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule
